// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A request is captured into operand registers, then executed for one cycle.
// The registered result is then held on the owner's response port until consumed.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on ties.
// Without it, requester 0 has fixed priority.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. Requesters keep valid and payload stable until ready.
// The arbiter asserts req ready only in IDLE and never while rst is high.
// resp valid stays up until the owner's resp ready. A resp ready seen while
// resp valid is 0, or a resp ready from the non-owner, is ignored.
module alu_arbiter #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_sel,
  input  logic [DATAW-1:0] req0_a,
  input  logic [DATAW-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_sel,
  input  logic [DATAW-1:0] req1_a,
  input  logic [DATAW-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [DATAW-1:0] resp0_data,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [DATAW-1:0] resp1_data,
  output logic [3:0]       alu_sel,
  output logic [DATAW-1:0] alu_a,
  output logic [DATAW-1:0] alu_b,
  input  logic [DATAW-1:0] alu_out,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q;
  logic [3:0]         sel_q;
  logic [DATAW-1:0]   a_q, b_q, result_q;
  logic               grant0, grant1;
  logic               accept;
  logic               owner_ready;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin: on a tie, grant the requester that was not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_q;
      grant1 = !last_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign last_d = accept ? grant1 : last_q;

  // Last-grant pointer; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  // Fixed priority: requester 0 always wins a tie.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  assign accept      = (state_q == IDLE) && !rst && (grant0 || grant1);
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept -> one execute cycle -> hold response until owner takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; reset blocks ready combinationally.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
      end
      RESP: begin
        resp0_valid = !owner_q;
        resp1_valid = owner_q;
      end
      default: ;
    endcase
  end

  // Operand registers: loaded on accept, held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= 1'b0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (accept) begin
      owner_q <= grant1;
      sel_q   <= grant1 ? req1_sel : req0_sel;
      a_q     <= grant1 ? req1_a   : req0_a;
      b_q     <= grant1 ? req1_b   : req0_b;
    end
  end

  // Result register: samples the shared ALU during the execute cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  result_q <= '0;
    else if (state_q == EXEC) result_q <= alu_out;
  end

  assign alu_sel     = sel_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp0_data  = result_q;
  assign resp1_data  = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed cases plus randomized traffic against a
// transaction-level model of the arbiter.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_sel, req1_sel;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0] resp0_data, resp1_data;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   dbg_state;

  alu_arbiter #(.DATAW(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .dbg_state_o(dbg_state)
  );

  // Shared ALU outside the arbiter; undefined codes yield 0.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (s)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      ALU_SLTU: return (a < b) ? W'(1) : W'(0);
      default:  return '0;
    endcase
  endfunction
  assign alu_out = alu_fn(alu_sel, alu_a, alu_b);

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // One op in flight: age 1 = executing, age 2 = response offered.
  bit           m_busy  = 1'b0;
  int           m_age   = 0;
  bit           m_owner = 1'b0;
  bit           m_last  = 1'b1;
  logic [3:0]   m_sel   = '0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, m_data = '0;
  logic [W-1:0] exp_q[$];
  bit           hs0_seen = 1'b0, hs1_seen = 1'b0;

  function automatic void predict(output bit r0, output bit r1, output bit v0, output bit v1);
    r0 = 1'b0;
    r1 = 1'b0;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
        if (m_last) r0 = 1'b1; else r1 = 1'b1;
`else
        r0 = 1'b1;
`endif
      end else begin
        r0 = req0_valid;
        r1 = req1_valid;
      end
    end
    v0 = m_busy && (m_age == 2) && !m_owner;
    v1 = m_busy && (m_age == 2) && m_owner;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    bit r0, r1, v0, v1;
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1;
      m_sel = '0; m_a = '0; m_b = '0; m_res = '0; m_data = '0;
      exp_q.delete();
    end else begin
      predict(r0, r1, v0, v1);
      if (!m_busy) begin
        if (r0 || r1) begin
          m_owner = r1;
          m_last  = r1;
          m_sel   = r1 ? req1_sel : req0_sel;
          m_a     = r1 ? req1_a : req0_a;
          m_b     = r1 ? req1_b : req0_b;
          m_res   = alu_fn(m_sel, m_a, m_b);
          exp_q.push_back(m_res);
          m_busy  = 1'b1;
          m_age   = 1;
        end
      end else if (m_age == 1) begin
        m_age  = 2;
        m_data = m_res;
      end else if ((v0 && resp0_ready) || (v1 && resp1_ready)) begin
        m_busy = 1'b0;
        void'(exp_q.pop_front());
      end
    end
  end

  // Every-cycle compare of all DUT outputs against the model.
  always @(negedge clk) begin : cmp
    bit er0, er1, ev0, ev1;
    predict(er0, er1, ev0, ev1);
    if (rst) begin er0 = 1'b0; er1 = 1'b0; end
    check("req0_ready", req0_ready, er0);
    check("req1_ready", req1_ready, er1);
    check("resp0_valid", resp0_valid, ev0);
    check("resp1_valid", resp1_valid, ev1);
    check("resp0_data", resp0_data, m_data);
    check("resp1_data", resp1_data, m_data);
    check("alu_sel", alu_sel, m_sel);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    if (!rst && ((ev0 && resp0_ready) || (ev1 && resp1_ready))) begin
      check("resp_queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("resp_take_data", ev0 ? resp0_data : resp1_data, exp_q[0]);
    end
    hs0_seen = req0_valid && req0_ready;
    hs1_seen = req1_valid && req1_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  // Issue one op from idle, check literal timing/result, then consume it.
  task automatic single_op(input bit idx, input logic [3:0] s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp, input string nm);
    if (idx) begin req1_valid = 1'b1; req1_sel = s; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_sel = s; req0_a = a; req0_b = b; end
    @(negedge clk);
    check({nm, "_ready"}, idx ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check({nm, "_exec_no_valid"}, resp0_valid | resp1_valid, 0);
    tick();
    @(negedge clk);
    check({nm, "_valid"}, idx ? resp1_valid : resp0_valid, 1);
    check({nm, "_other_valid"}, idx ? resp0_valid : resp1_valid, 0);
    check({nm, "_data"}, idx ? resp1_data : resp0_data, exp);
    check({nm, "_alu_sel_hold"}, alu_sel, s);
    check({nm, "_alu_a_hold"}, alu_a, a);
    tick();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int grants[4];
  int ngr;

  initial begin
    req0_valid = 1'b0; req0_sel = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_sel = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Reset state, with both requests valid to show ready stays low.
    repeat (2) tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp_data", resp0_data, 0);
    check("rst_alu_a", alu_a, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    single_op(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, "add");

    // SRA on req1 with a stalled consumer and a competing req0.
    req1_valid = 1'b1; req1_sel = ALU_SRA; req1_a = 32'h8000_0000; req1_b = 32'd4;
    @(negedge clk);
    check("sra_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_sel = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
    resp0_ready = 1'b1;
    @(negedge clk);
    check("sra_exec_req0_ready", req0_ready, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sra_resp1_valid", resp1_valid, 1);
      check("sra_resp1_data", resp1_data, 32'hF800_0000);
      check("sra_req0_ready", req0_ready, 0);
      check("sra_resp0_valid", resp0_valid, 0);
      tick();
    end
    resp1_ready = 1'b1;
    resp0_ready = 1'b0;
    @(negedge clk);
    check("sra_resp1_take", resp1_valid, 1);
    tick();
    resp1_ready = 1'b0;
    @(negedge clk);
    check("sra_then_req0_ready", req0_ready, 1);
    check("sra_resp1_dropped", resp1_valid, 0);
    check("sra_data_hold", resp1_data, 32'hF800_0000);
    tick();
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    check("after_sra_add_data", resp0_data, 32'd3);
    tick();
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;

    single_op(1'b0, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, "sltu");
    single_op(1'b0, ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, "slt");
    single_op(1'b1, 4'hC, 32'd9, 32'd9, 32'd0, "undef_sel");

    // Consume in the first RESP cycle; the waiting req1 is taken only in IDLE.
    req0_valid = 1'b1; req0_sel = ALU_XOR; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_0FF0;
    @(negedge clk);
    check("b2b_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_sel = ALU_OR; req1_a = 32'h10; req1_b = 32'h01;
    @(negedge clk);
    check("b2b_exec_req1_ready", req1_ready, 0);
    tick();
    resp0_ready = 1'b1;
    @(negedge clk);
    check("b2b_resp0_valid", resp0_valid, 1);
    check("b2b_resp0_data", resp0_data, 32'h0000_FF00);
    check("b2b_resp_req1_ready", req1_ready, 0);
    tick();
    resp0_ready = 1'b0;
    @(negedge clk);
    check("b2b_resp0_gone", resp0_valid, 0);
    check("b2b_idle_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    check("b2b_resp1_valid", resp1_valid, 1);
    check("b2b_resp1_data", resp1_data, 32'h11);
    tick();
    resp1_ready = 1'b1;
    tick();
    resp1_ready = 1'b0;

    // Reset while req0's AND is executing.
    req0_valid = 1'b1; req0_sel = ALU_AND; req0_a = 32'd3; req0_b = 32'd1;
    @(negedge clk);
    check("rstx_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("rstx_exec_alu_a", alu_a, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("rstx_req0_ready", req0_ready, 0);
    check("rstx_resp0_valid", resp0_valid, 0);
    check("rstx_resp0_data", resp0_data, 0);
    check("rstx_alu_sel", alu_sel, 0);
    check("rstx_alu_a", alu_a, 0);
    check("rstx_alu_b", alu_b, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstx_no_resp0", resp0_valid, 0);
      tick();
    end

    // Both requesters continuously valid with SUB ops.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_sel = ALU_SUB; req0_a = rnd_word(); req0_b = rnd_word();
    req1_valid = 1'b1; req1_sel = ALU_SUB; req1_a = rnd_word(); req1_b = rnd_word();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready && ngr < 4) begin grants[ngr] = 0; ngr++; end
      else if (req1_ready && ngr < 4) begin grants[ngr] = 1; ngr++; end
      tick();
      if (hs0_seen) begin req0_a = rnd_word(); req0_b = rnd_word(); end
      if (hs1_seen) begin req1_a = rnd_word(); req1_b = rnd_word(); end
    end
    check("tie_grant_count", ngr, 4);
`ifdef ALU_ARB_RR_EN
    check("tie_grant0", grants[0], 0);
    check("tie_grant1", grants[1], 1);
    check("tie_grant2", grants[2], 0);
    check("tie_grant3", grants[3], 1);
`else
    check("tie_grant0", grants[0], 0);
    check("tie_grant1", grants[1], 0);
    check("tie_grant2", grants[2], 0);
    check("tie_grant3", grants[3], 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Randomized traffic with occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      if (!req0_valid || hs0_seen) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        if (req0_valid) begin
          req0_sel = 4'($urandom_range(0, 15)); req0_a = rnd_word(); req0_b = rnd_word();
        end
      end
      if (!req1_valid || hs1_seen) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        if (req1_valid) begin
          req1_sel = 4'($urandom_range(0, 15)); req1_a = rnd_word(); req1_b = rnd_word();
        end
      end
      resp0_ready = ($urandom_range(0, 2) != 0);
      resp1_ready = ($urandom_range(0, 2) != 0);
    end

    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATAW, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports, n in {0,1}: reqn_valid  input  1  request n presented.
REQ-005 SHALL have ports: reqn_ready  output  1  request n accepted this cycle.
REQ-006 SHALL have ports: reqn_sel  input  4  ALU operation code, the ALU_* encodings.
REQ-007 SHALL have ports: reqn_a, reqn_b  input  DATAW  operands.
REQ-008 SHALL have ports: respn_valid  output  1  result for requester n available.
REQ-009 SHALL have ports: respn_ready  input  1  requester n consumes result.
REQ-010 SHALL have ports: respn_data  output  DATAW  result for requester n.
REQ-011 SHALL have ports: alu_sel  output  4, alu_a / alu_b  output  DATAW  drive shared ALU.
REQ-012 SHALL have port: alu_out  input  DATAW  combinational result of shared ALU.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 In IDLE, reqn_ready SHALL be 1 only for the granted requester with reqn_valid=1; outside IDLE both readys 0.
REQ-015 Handshake reqn_valid&reqn_ready SHALL capture sel/a/b into operand registers, record owner, go to EXEC.
REQ-016 Requesters SHALL hold valid and payload stable until ready; arbiter never drops a valid request unaccepted except by reset.
REQ-017 alu_sel/alu_a/alu_b SHALL come only from operand registers (never combinationally from request ports).
REQ-018 In EXEC (exactly one cycle), alu_out SHALL be registered into result register; go to RESP.
REQ-019 In RESP, respn_valid SHALL be 1 for owner only; respn_data = result register; other resp_valid 0.
REQ-020 RESP SHALL persist until owner's respn_ready=1, then go to IDLE; no request accepted in RESP cycle.
REQ-021 Latency: accept at cycle N -> resp_valid at N+2; max throughput one op per 3 cycles.
REQ-022 respn_data SHALL hold last result when respn_valid=0; resp_ready with resp_valid=0 SHALL be ignored.
REQ-023 Non-owner respn_ready SHALL have no effect.
REQ-024 Operand registers SHALL hold values after EXEC until next accept.
REQ-025 Undefined sel codes SHALL be passed through unchanged; result is whatever alu_out returns (0).

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, reqn_ready 0, respn_valid 0, respn_data 0, alu_sel/alu_a/alu_b 0, last-grant pointer = 1.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight op; no response issued after reset release.
REQ-028 First accept SHALL occur no earlier than first rising edge after rst deasserts.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin; both valid in IDLE -> grant requester not last granted; pointer updates on each accept.
REQ-030 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; no pointer.
REQ-031 Single valid requester SHALL be granted in IDLE regardless of mode.

Verification
REQ-032 req0 ADD a=5,b=7 alone -> req0_ready at N, resp0_valid at N+2, resp0_data=12, resp1_valid 0.
REQ-033 req1 SRA a=0x80000000,b=4, resp1_ready held 0 for 3 cycles -> resp1_valid/data=0xF8000000 stable, req0_ready 0 throughout.
REQ-034 Both valid continuously, SUB ops, RR_EN defined -> grants 0,1,0,1 after reset; undefined -> 0,0,0,0.
REQ-035 rst asserted in EXEC of req0 AND 3,1 -> all outputs 0 same cycle, no resp0_valid after release.
REQ-036 resp0_ready=1 same cycle resp0_valid rises while req1_valid=1 -> IDLE next cycle, req1_ready 1 that cycle, not in RESP cycle.
REQ-037 req0 SLTU a=1,b=0xFFFFFFFF then SLT same operands -> resp0_data 1 then 0.
